// File: rtl/cw_encoder_19_8.sv
// Streaming (19,8) single-error-correcting block encoder with optional
// single-bit error injection, a 2-entry output queue and a handshake counter.
module cw_encoder_19_8 #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             inj_en,
   input  logic [4:0]       inj_pos,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [18:0]      out_cw,
   output logic [CNT_W-1:0] word_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_t;

   occ_t        occ;
   logic [18:0] tail_cw;
   logic [18:0] enc_cw;
   logic [18:0] new_cw;
   logic        push;
   logic        pop;

   function automatic logic [10:0] parity(input logic [7:0] d);
      logic [10:0] p;
      p[0]  = d[1] ^ d[3] ^ d[4] ^ d[5] ^ d[6] ^ d[7];
      p[1]  = d[2] ^ d[3] ^ d[5];
      p[2]  = d[0] ^ d[1] ^ d[3];
      p[3]  = d[3] ^ d[7];
      p[4]  = d[0] ^ d[1] ^ d[4] ^ d[6];
      p[5]  = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[7];
      p[6]  = d[2] ^ d[3] ^ d[5];
      p[7]  = d[0] ^ d[2] ^ d[3];
      p[8]  = d[0] ^ d[1] ^ d[3] ^ d[7];
      p[9]  = d[1] ^ d[4] ^ d[6] ^ d[7];
      p[10] = d[0] ^ d[2] ^ d[3] ^ d[4] ^ d[5];
      return p;
   endfunction

   // Positions 19..31 are deliberately out of range and leave the word intact.
   always_comb begin
      enc_cw = {in_data, parity(in_data)};
      new_cw = enc_cw;
      if (inj_en && (inj_pos <= 5'd18)) begin
         new_cw[inj_pos] = ~enc_cw[inj_pos];
      end
   end

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   // out_cw is the head register itself; tail_cw only holds the second entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ       <= EMPTY;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_cw    <= '0;
         tail_cw   <= '0;
         word_cnt  <= '0;
      end else begin
         if (pop) begin
            word_cnt <= word_cnt + CNT_W'(1);
         end
         case (occ)
            EMPTY: begin
               in_ready <= 1'b1;
               if (push) begin
                  out_cw    <= new_cw;
                  out_valid <= 1'b1;
                  occ       <= ONE;
               end
            end
            ONE: begin
               if (push && pop) begin
                  out_cw <= new_cw;
               end else if (push) begin
                  tail_cw  <= new_cw;
                  in_ready <= 1'b0;
                  occ      <= FULL;
               end else if (pop) begin
                  out_valid <= 1'b0;
                  occ       <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  out_cw   <= tail_cw;
                  in_ready <= 1'b1;
                  occ      <= ONE;
               end
            end
            default: begin
               occ       <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cw_encoder_19_8.sv
// Self-checking bench for cw_encoder_19_8: a queue-based reference model is
// compared against two DUT instances (default and 4-bit counter) every cycle.
module tb_cw_encoder_19_8;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        inj_en;
   logic [4:0]  inj_pos;
   logic        out_ready;

   logic        in_ready;
   logic        out_valid;
   logic [18:0] out_cw;
   logic [15:0] word_cnt;

   logic        in_ready4;
   logic        out_valid4;
   logic [18:0] out_cw4;
   logic [3:0]  word_cnt4;

   int n_compared;
   int n_mismatched;

   // Reference model state
   logic [18:0] model_q [$];
   bit          model_armed;
   int          model_cnt;
   bit          model_cw_zero;
   bit          m_push;
   bit          m_pop;

   // Data-bit masks of each parity bit, index 0 = p0
   localparam logic [7:0] PMASK [11] = '{8'hFA, 8'h2C, 8'h0B, 8'h88, 8'h53,
                                        8'h97, 8'h2C, 8'h0D, 8'h8B, 8'hD2, 8'h3D};

   cw_encoder_19_8 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .inj_en    (inj_en),
      .inj_pos   (inj_pos),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_cw    (out_cw),
      .word_cnt  (word_cnt)
   );

   cw_encoder_19_8 #(.CNT_W(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready4),
      .in_data   (in_data),
      .inj_en    (inj_en),
      .inj_pos   (inj_pos),
      .out_valid (out_valid4),
      .out_ready (out_ready),
      .out_cw    (out_cw4),
      .word_cnt  (word_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [18:0] modelEncode(input logic [7:0] d, input logic e,
                                               input logic [4:0] p);
      logic [18:0] cw;
      cw = {d, 11'd0};
      for (int i = 0; i < 11; i++) begin
         cw[i] = ^(d & PMASK[i]);
      end
      if (e && (p < 5'd19)) begin
         cw[p] = ~cw[p];
      end
      return cw;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic e,
                                input logic [4:0] p, input logic r);
      in_valid  = v;
      in_data   = d;
      inj_en    = e;
      inj_pos   = p;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   // Pop first, then push: with one entry queued the new word becomes head.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_q.delete();
         model_armed   = 1'b0;
         model_cnt     = 0;
         model_cw_zero = 1'b1;
      end else begin
         m_push = in_valid && model_armed && (model_q.size() < 2);
         m_pop  = (model_q.size() > 0) && out_ready;
         model_armed = 1'b1;
         if (m_pop) begin
            void'(model_q.pop_front());
            model_cnt++;
         end
         if (m_push) begin
            model_q.push_back(modelEncode(in_data, inj_en, inj_pos));
            model_cw_zero = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      checkOutput("in_ready", 32'(in_ready), 32'(model_armed && (model_q.size() < 2)));
      checkOutput("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
      checkOutput("word_cnt", 32'(word_cnt), 32'(model_cnt % 65536));
      checkOutput("in_ready4", 32'(in_ready4), 32'(model_armed && (model_q.size() < 2)));
      checkOutput("out_valid4", 32'(out_valid4), 32'(model_q.size() > 0));
      checkOutput("word_cnt4", 32'(word_cnt4), 32'(model_cnt % 16));
      if (model_q.size() > 0) begin
         checkOutput("out_cw", 32'(out_cw), 32'(model_q[0]));
         checkOutput("out_cw4", 32'(out_cw4), 32'(model_q[0]));
      end else if (model_cw_zero) begin
         checkOutput("out_cw_reset", 32'(out_cw), 32'd0);
      end
   end

   task automatic releaseReset();
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      inj_en    = 1'b0;
      inj_pos   = 5'd0;
      out_ready = 1'b0;

      checkOutput("model_01", 32'(modelEncode(8'h01, 1'b0, 5'd0)), 32'h00DB4);
      checkOutput("model_80", 32'(modelEncode(8'h80, 1'b0, 5'd0)), 32'h40329);
      checkOutput("model_FF", 32'(modelEncode(8'hFF, 1'b0, 5'd0)), 32'h7FCE6);
      checkOutput("model_inj11", 32'(modelEncode(8'h01, 1'b1, 5'd11)), 32'h005B4);

      #2;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset_out_cw", 32'(out_cw), 32'd0);
      releaseReset();
      checkOutput("ready_after_reset", 32'(in_ready), 32'd1);

      applyStimulus(1'b1, 8'h01, 1'b0, 5'd0, 1'b1);
      checkOutput("first_cw", 32'(out_cw), 32'h00DB4);
      checkOutput("first_valid", 32'(out_valid), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
      checkOutput("first_cnt", 32'(word_cnt), 32'd1);

      applyStimulus(1'b1, 8'h80, 1'b0, 5'd0, 1'b1);
      checkOutput("b2b_80", 32'(out_cw), 32'h40329);
      applyStimulus(1'b1, 8'hFF, 1'b0, 5'd0, 1'b1);
      checkOutput("b2b_FF", 32'(out_cw), 32'h7FCE6);
      applyStimulus(1'b1, 8'h00, 1'b0, 5'd0, 1'b1);
      checkOutput("b2b_00", 32'(out_cw), 32'h00000);
      checkOutput("b2b_valid", 32'(out_valid), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 5'd0, 1'b1);

      applyStimulus(1'b1, 8'h01, 1'b1, 5'd11, 1'b1);
      checkOutput("inj_11", 32'(out_cw), 32'h005B4);
      applyStimulus(1'b1, 8'h01, 1'b1, 5'd25, 1'b1);
      checkOutput("inj_25", 32'(out_cw), 32'h00DB4);
      applyStimulus(1'b0, 8'h00, 1'b0, 5'd0, 1'b1);

      applyStimulus(1'b1, 8'h01, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 8'h80, 1'b0, 5'd0, 1'b0);
      checkOutput("full_in_ready", 32'(in_ready), 32'd0);
      checkOutput("full_head", 32'(out_cw), 32'h00DB4);
      applyStimulus(1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
      checkOutput("hold_head", 32'(out_cw), 32'h00DB4);
      applyStimulus(1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
      checkOutput("drain_second", 32'(out_cw), 32'h40329);
      checkOutput("ready_after_pop", 32'(in_ready), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
      checkOutput("drained", 32'(out_valid), 32'd0);

      applyStimulus(1'b1, 8'h01, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 8'h80, 1'b0, 5'd0, 1'b0);
      in_valid = 1'b0;
      #3 rst = 1'b1;
      #1;
      checkOutput("midrst_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_cw", 32'(out_cw), 32'd0);
      checkOutput("midrst_cnt", 32'(word_cnt), 32'd0);
      checkOutput("midrst_ready", 32'(in_ready), 32'd0);
      releaseReset();
      applyStimulus(1'b1, 8'hFF, 1'b0, 5'd0, 1'b1);
      checkOutput("post_rst_cw", 32'(out_cw), 32'h7FCE6);
      applyStimulus(1'b0, 8'h00, 1'b0, 5'd0, 1'b1);

      #3 rst = 1'b1;
      releaseReset();
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, 8'(i * 13), 1'b0, 5'd0, 1'b1);
      end
      repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
      checkOutput("wrap_cnt4", 32'(word_cnt4), 32'd1);
      checkOutput("wrap_cnt16", 32'(word_cnt), 32'd17);

      for (int i = 0; i < 800; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                       5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0));
      end
      repeat (4) applyStimulus(1'b0, 8'h00, 1'b0, 5'd0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
